// File: rtl/reg_bus_initiator.sv
// rtl/reg_bus_initiator.sv - word command to byte-serial register bus initiator
// One command in, 1-4 reg_write/reg_read strobes out, one response back.
module reg_bus_initiator #(
    parameter int pBYTECNT_SIZE = 7,
    parameter int pREAD_LATENCY = 1
) (
    input  logic                     usb_clk,
    input  logic                     reset_pin_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_write,
    input  logic [7:0]               cmd_address,
    input  logic [1:0]               cmd_len,
    input  logic [31:0]              cmd_wdata,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic                     rsp_write,
    output logic [31:0]              rsp_rdata,
    output logic [7:0]               reg_address,
    output logic [pBYTECNT_SIZE-1:0] reg_bytecnt,
    output logic [7:0]               write_data,
    output logic                     reg_write,
    output logic                     reg_read,
    input  logic [7:0]               read_data,
    output logic                     busy
);

    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_RESP} state_t;

    localparam int PIPE_DEPTH = (pREAD_LATENCY == 0) ? 1 : pREAD_LATENCY;
    localparam int CAP_STAGE  = PIPE_DEPTH - 1;

    state_t          state_q, state_d;
    logic            cmd_ready_q, cmd_ready_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic            rsp_write_q, rsp_write_d;
    logic [31:0]     rsp_rdata_q, rsp_rdata_d;
    logic [7:0]      reg_address_q, reg_address_d;
    logic [1:0]      idx_q, idx_d;
    logic [1:0]      len_q, len_d;
    logic [23:0]     wdata_q, wdata_d;
    logic [7:0]      write_data_q, write_data_d;
    logic            reg_write_q, reg_write_d;
    logic            reg_read_q, reg_read_d;
    logic            busy_q, busy_d;
    logic [PIPE_DEPTH-1:0] pipe_v_q, pipe_v_d;
    logic [1:0]      pipe_idx_q [PIPE_DEPTH];
    logic [1:0]      pipe_idx_d [PIPE_DEPTH];
    logic            cap_v;
    logic [1:0]      cap_idx;

    // The capture pipeline follows the registered strobe, so stage k sees read_data k+1 cycles late.
    always_comb begin
        cap_v   = (pREAD_LATENCY == 0) ? reg_read_q : pipe_v_q[CAP_STAGE];
        cap_idx = (pREAD_LATENCY == 0) ? idx_q      : pipe_idx_q[CAP_STAGE];
    end

    always_comb begin
        state_d       = state_q;
        cmd_ready_d   = cmd_ready_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_write_d   = rsp_write_q;
        rsp_rdata_d   = rsp_rdata_q;
        reg_address_d = reg_address_q;
        idx_d         = idx_q;
        len_d         = len_q;
        wdata_d       = wdata_q;
        write_data_d  = write_data_q;
        reg_write_d   = reg_write_q;
        reg_read_d    = reg_read_q;

        pipe_v_d[0]   = reg_read_q;
        pipe_idx_d[0] = idx_q;
        for (int k = 1; k < PIPE_DEPTH; k++) begin
            pipe_v_d[k]   = pipe_v_q[k-1];
            pipe_idx_d[k] = pipe_idx_q[k-1];
        end

        if (cap_v) begin
            case (cap_idx)
                2'd0:    rsp_rdata_d[7:0]   = read_data;
                2'd1:    rsp_rdata_d[15:8]  = read_data;
                2'd2:    rsp_rdata_d[23:16] = read_data;
                default: rsp_rdata_d[31:24] = read_data;
            endcase
        end

        case (state_q)
            S_IDLE: begin
                rsp_rdata_d = '0;
                if (cmd_valid && cmd_ready_q) begin
                    reg_address_d = cmd_address;
                    len_d         = cmd_len;
                    idx_d         = 2'd0;
                    rsp_write_d   = cmd_write;
                    cmd_ready_d   = 1'b0;
                    if (cmd_write) begin
                        state_d      = S_WRITE;
                        reg_write_d  = 1'b1;
                        write_data_d = cmd_wdata[7:0];
                        wdata_d      = cmd_wdata[31:8];
                    end else begin
                        state_d    = S_READ;
                        reg_read_d = 1'b1;
                    end
                end
            end
            S_WRITE: begin
                if (idx_q == len_q) begin
                    reg_write_d = 1'b0;
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                end else begin
                    idx_d        = idx_q + 2'd1;
                    write_data_d = wdata_q[7:0];
                    wdata_d      = {8'h00, wdata_q[23:8]};
                end
            end
            S_READ: begin
                if (idx_q == len_q) begin
                    reg_read_d = 1'b0;
                    if (pREAD_LATENCY == 0) begin
                        state_d     = S_RESP;
                        rsp_valid_d = 1'b1;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end else begin
                    idx_d = idx_q + 2'd1;
                end
            end
            S_DRAIN: begin
                if (cap_v && (cap_idx == len_q)) begin
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                end
            end
            default: begin
                state_d     = S_IDLE;
                cmd_ready_d = 1'b1;
                rsp_valid_d = 1'b0;
                reg_write_d = 1'b0;
                reg_read_d  = 1'b0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge usb_clk or negedge reset_pin_n) begin
        if (!reset_pin_n) begin
            state_q       <= S_IDLE;
            cmd_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_write_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            reg_address_q <= '0;
            idx_q         <= '0;
            len_q         <= '0;
            wdata_q       <= '0;
            write_data_q  <= '0;
            reg_write_q   <= 1'b0;
            reg_read_q    <= 1'b0;
            busy_q        <= 1'b0;
            pipe_v_q      <= '0;
            for (int k = 0; k < PIPE_DEPTH; k++) pipe_idx_q[k] <= '0;
        end else begin
            state_q       <= state_d;
            cmd_ready_q   <= cmd_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_write_q   <= rsp_write_d;
            rsp_rdata_q   <= rsp_rdata_d;
            reg_address_q <= reg_address_d;
            idx_q         <= idx_d;
            len_q         <= len_d;
            wdata_q       <= wdata_d;
            write_data_q  <= write_data_d;
            reg_write_q   <= reg_write_d;
            reg_read_q    <= reg_read_d;
            busy_q        <= busy_d;
            pipe_v_q      <= pipe_v_d;
            for (int k = 0; k < PIPE_DEPTH; k++) pipe_idx_q[k] <= pipe_idx_d[k];
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_write   = rsp_write_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign reg_address = reg_address_q;
    assign reg_bytecnt = pBYTECNT_SIZE'(idx_q);
    assign write_data  = write_data_q;
    assign reg_write   = reg_write_q;
    assign reg_read    = reg_read_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_reg_bus_initiator.sv
// tb/tb_reg_bus_initiator.sv - self-checking bench for reg_bus_initiator
module tb_reg_bus_initiator;

    logic usb_clk = 1'b0;
    always #5 usb_clk = ~usb_clk;
    logic reset_pin_n;

    logic        cmd_valid, cmd_ready, cmd_write;
    logic [7:0]  cmd_address;
    logic [1:0]  cmd_len;
    logic [31:0] cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_write;
    logic [31:0] rsp_rdata;
    logic [7:0]  reg_address, write_data, read_data;
    logic [6:0]  reg_bytecnt;
    logic        reg_write, reg_read, busy;

    logic        cmd_valid0, cmd_ready0, cmd_write0;
    logic [7:0]  cmd_address0;
    logic [1:0]  cmd_len0;
    logic [31:0] cmd_wdata0;
    logic        rsp_valid0, rsp_ready0, rsp_write0;
    logic [31:0] rsp_rdata0;
    logic [7:0]  reg_address0, write_data0, read_data0;
    logic [6:0]  reg_bytecnt0;
    logic        reg_write0, reg_read0, busy0;

    reg_bus_initiator #(.pBYTECNT_SIZE(7), .pREAD_LATENCY(1)) dut (
        .usb_clk(usb_clk), .reset_pin_n(reset_pin_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_address(cmd_address), .cmd_len(cmd_len), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
        .reg_address(reg_address), .reg_bytecnt(reg_bytecnt), .write_data(write_data),
        .reg_write(reg_write), .reg_read(reg_read), .read_data(read_data), .busy(busy)
    );

    reg_bus_initiator #(.pBYTECNT_SIZE(7), .pREAD_LATENCY(0)) dut0 (
        .usb_clk(usb_clk), .reset_pin_n(reset_pin_n),
        .cmd_valid(cmd_valid0), .cmd_ready(cmd_ready0), .cmd_write(cmd_write0),
        .cmd_address(cmd_address0), .cmd_len(cmd_len0), .cmd_wdata(cmd_wdata0),
        .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0), .rsp_write(rsp_write0), .rsp_rdata(rsp_rdata0),
        .reg_address(reg_address0), .reg_bytecnt(reg_bytecnt0), .write_data(write_data0),
        .reg_write(reg_write0), .reg_read(reg_read0), .read_data(read_data0), .busy(busy0)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic        w;
        logic [31:0] d;
    } rsp_t;
    rsp_t sb[$];
    rsp_t sb0[$];
    rsp_t mon_exp, mon_exp0;

    logic [7:0] rd_bytes [4];

    // Responder with one cycle of read latency; idle filler exposes wrong sampling cycles.
    always @(posedge usb_clk or negedge reset_pin_n) begin
        if (!reset_pin_n) read_data <= 8'h00;
        else              read_data <= reg_read ? rd_bytes[reg_bytecnt[1:0]] : 8'h5A;
    end
    assign read_data0 = reg_read0 ? rd_bytes[reg_bytecnt0[1:0]] : 8'hC3;

    always @(negedge usb_clk) begin
        if (reset_pin_n) begin
            if (reg_write || reg_read) begin
                checks++;
                if (reg_write && reg_read) begin
                    failures++;
                    $display("FAIL strobe_overlap: reg_write=%b reg_read=%b, required not both", reg_write, reg_read);
                end
            end
            if (rsp_valid && rsp_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL rsp_unexpected: got w=%b d=%h, required no response", rsp_write, rsp_rdata);
                end else begin
                    mon_exp = sb.pop_front();
                    if ({rsp_write, rsp_rdata} !== mon_exp) begin
                        failures++;
                        $display("FAIL rsp_data: got w=%b d=%h, required w=%b d=%h",
                                 rsp_write, rsp_rdata, mon_exp.w, mon_exp.d);
                    end
                end
            end
            if (rsp_valid0 && rsp_ready0) begin
                checks++;
                if (sb0.size() == 0) begin
                    failures++;
                    $display("FAIL rsp0_unexpected: got w=%b d=%h", rsp_write0, rsp_rdata0);
                end else begin
                    mon_exp0 = sb0.pop_front();
                    if ({rsp_write0, rsp_rdata0} !== mon_exp0) begin
                        failures++;
                        $display("FAIL rsp0_data: got w=%b d=%h, required w=%b d=%h",
                                 rsp_write0, rsp_rdata0, mon_exp0.w, mon_exp0.d);
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge usb_clk);
        #1;
    endtask

    // Issues one command (cmd_ready assumed high), checks every bus cycle up to the response.
    task automatic run_cmd(input logic w, input logic [7:0] a, input logic [1:0] len,
                           input logic [31:0] wd, input logic [31:0] exp);
        int n;
        int lat;
        n   = int'(len) + 1;
        lat = w ? 0 : 1;
        cmd_valid = 1'b1; cmd_write = w; cmd_address = a; cmd_len = len; cmd_wdata = wd;
        sb.push_back({w, w ? 32'h0 : exp});
        step();
        cmd_valid = 1'b0; cmd_address = 8'($urandom); cmd_wdata = $urandom; cmd_write = ~w;
        for (int c = 1; c <= n + lat + 1; c++) begin
            @(negedge usb_clk);
            checks++;
            if (c <= n) begin
                if (reg_write !== w || reg_read !== ~w || reg_bytecnt !== 7'(c-1) || reg_address !== a ||
                    (w && write_data !== wd[8*(c-1) +: 8]) || rsp_valid !== 1'b0 || cmd_ready !== 1'b0 ||
                    busy !== 1'b1) begin
                    failures++;
                    $display("FAIL strobe_cycle%0d: wr=%b rd=%b cnt=%0d addr=%h wd=%h rv=%b cr=%b, required wr=%b cnt=%0d addr=%h wd=%h rv=0 cr=0",
                             c, reg_write, reg_read, reg_bytecnt, reg_address, write_data, rsp_valid, cmd_ready,
                             w, c-1, a, wd[8*(c-1) +: 8]);
                end
            end else if (c <= n + lat) begin
                if (reg_write !== 1'b0 || reg_read !== 1'b0 || rsp_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL drain_cycle%0d: wr=%b rd=%b rv=%b, required 0 0 0", c, reg_write, reg_read, rsp_valid);
                end
            end else begin
                if (rsp_valid !== 1'b1 || reg_write !== 1'b0 || reg_read !== 1'b0 || cmd_ready !== 1'b0 ||
                    reg_address !== a || reg_bytecnt !== 7'(len)) begin
                    failures++;
                    $display("FAIL rsp_cycle%0d: rv=%b wr=%b rd=%b cr=%b addr=%h cnt=%0d, required rv=1 0 0 0 addr=%h cnt=%0d",
                             c, rsp_valid, reg_write, reg_read, cmd_ready, reg_address, reg_bytecnt, a, len);
                end
            end
        end
    endtask

    task automatic test_reset();
        reset_pin_n = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_address = 8'h00; cmd_len = 2'd0; cmd_wdata = 32'h0; rsp_ready = 1'b0;
        cmd_valid0 = 1'b0; cmd_write0 = 1'b0; cmd_address0 = 8'h00; cmd_len0 = 2'd0; cmd_wdata0 = 32'h0; rsp_ready0 = 1'b1;
        for (int k = 0; k < 4; k++) rd_bytes[k] = 8'h00;
        repeat (3) @(negedge usb_clk);
        checks++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_write !== 1'b0 || rsp_rdata !== 32'h0 ||
            reg_address !== 8'h0 || reg_bytecnt !== 7'h0 || write_data !== 8'h0 || reg_write !== 1'b0 ||
            reg_read !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: cr=%b rv=%b rw=%b rd=%h addr=%h cnt=%h wd=%h wr=%b rdst=%b busy=%b, required 1 0 0 0 0 0 0 0 0 0",
                     cmd_ready, rsp_valid, rsp_write, rsp_rdata, reg_address, reg_bytecnt, write_data, reg_write, reg_read, busy);
        end
        step();
        reset_pin_n = 1'b1;
        repeat (2) @(negedge usb_clk);
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || cmd_ready0 !== 1'b1 || rsp_valid0 !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: cr=%b busy=%b cr0=%b rv0=%b, required 1 0 1 0", cmd_ready, busy, cmd_ready0, rsp_valid0);
        end
        step();
    endtask

    task automatic test_write();
        rsp_ready = 1'b1;
        run_cmd(1'b1, 8'h04, 2'd3, 32'hDEADBEEF, 32'h0);
        step();
    endtask

    task automatic test_read();
        rd_bytes[0] = 8'h11; rd_bytes[1] = 8'h22; rd_bytes[2] = 8'h33; rd_bytes[3] = 8'h44;
        rsp_ready = 1'b1;
        run_cmd(1'b0, 8'h04, 2'd3, 32'h0, 32'h44332211);
        step();
        rd_bytes[0] = 8'h9C; rd_bytes[1] = 8'h3E;
        run_cmd(1'b0, 8'h21, 2'd1, 32'h0, 32'h00003E9C);
        step();
    endtask

    task automatic test_read_lat0();
        rd_bytes[0] = 8'hAB;
        cmd_valid0 = 1'b1; cmd_write0 = 1'b0; cmd_address0 = 8'h10; cmd_len0 = 2'd0;
        sb0.push_back({1'b0, 32'h000000AB});
        step();
        cmd_valid0 = 1'b0;
        @(negedge usb_clk);
        checks++;
        if (reg_read0 !== 1'b1 || reg_bytecnt0 !== 7'd0 || rsp_valid0 !== 1'b0) begin
            failures++;
            $display("FAIL lat0_strobe: rd=%b cnt=%0d rv=%b, required 1 0 0", reg_read0, reg_bytecnt0, rsp_valid0);
        end
        @(negedge usb_clk);
        checks++;
        if (reg_read0 !== 1'b0 || rsp_valid0 !== 1'b1 || rsp_rdata0 !== 32'h000000AB) begin
            failures++;
            $display("FAIL lat0_rsp: rd=%b rv=%b d=%h, required 0 1 000000ab", reg_read0, rsp_valid0, rsp_rdata0);
        end
        step();
        step();
    endtask

    task automatic test_stall();
        rd_bytes[0] = 8'h5E; rd_bytes[1] = 8'hC0;
        rsp_ready = 1'b0;
        run_cmd(1'b0, 8'h33, 2'd1, 32'h0, 32'h0000C05E);
        step();
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_address = 8'h77; cmd_len = 2'd3; cmd_wdata = 32'h01020304;
        for (int c = 0; c < 10; c++) begin
            @(negedge usb_clk);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0000C05E || rsp_write !== 1'b0 || cmd_ready !== 1'b0 ||
                reg_write !== 1'b0 || reg_read !== 1'b0) begin
                failures++;
                $display("FAIL stall_cycle%0d: rv=%b d=%h w=%b cr=%b wr=%b rd=%b, required 1 0000c05e 0 0 0 0",
                         c, rsp_valid, rsp_rdata, rsp_write, cmd_ready, reg_write, reg_read);
            end
        end
        step();
        rsp_ready = 1'b1;
        step();
        checks++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL stall_release: cr=%b rv=%b, required 1 0", cmd_ready, rsp_valid);
        end
        run_cmd(1'b1, 8'h78, 2'd2, 32'hAA_CAFE12, 32'h0);
        step();
    endtask

    task automatic test_reset_mid_write();
        rsp_ready = 1'b1;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_address = 8'h08; cmd_len = 2'd3; cmd_wdata = 32'h87654321;
        step();
        cmd_valid = 1'b0;
        repeat (3) @(negedge usb_clk);
        checks++;
        if (reg_write !== 1'b1 || reg_bytecnt !== 7'd2 || write_data !== 8'h65) begin
            failures++;
            $display("FAIL abort_pre: wr=%b cnt=%0d wd=%h, required 1 2 65", reg_write, reg_bytecnt, write_data);
        end
        #1 reset_pin_n = 1'b0;
        #1;
        checks++;
        if (reg_write !== 1'b0 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL abort_async: wr=%b busy=%b rv=%b, required 0 0 0", reg_write, busy, rsp_valid);
        end
        step();
        step();
        reset_pin_n = 1'b1;
        @(negedge usb_clk);
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL abort_ready: cr=%b, required 1", cmd_ready);
        end
        for (int c = 0; c < 8; c++) begin
            @(negedge usb_clk);
            checks++;
            if (rsp_valid !== 1'b0 || reg_write !== 1'b0) begin
                failures++;
                $display("FAIL abort_quiet%0d: rv=%b wr=%b, required 0 0", c, rsp_valid, reg_write);
            end
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [1:0]  len;
        logic [31:0] wd, exp;
        rsp_ready = 1'b1;
        rd_bytes[0] = 8'hA1; rd_bytes[1] = 8'hB2; rd_bytes[2] = 8'hC3; rd_bytes[3] = 8'hD4;
        run_cmd(1'b1, 8'h40, 2'd1, 32'h0000BEAD, 32'h0);
        step();
        run_cmd(1'b0, 8'h41, 2'd2, 32'h0, 32'h00C3B2A1);
        step();
        for (int r = 0; r < 6; r++) begin
            len = 2'($urandom_range(0, 3));
            wd  = $urandom;
            for (int k = 0; k < 4; k++) rd_bytes[k] = 8'($urandom);
            exp = 32'h0;
            for (int k = 0; k <= int'(len); k++) exp[8*k +: 8] = rd_bytes[k];
            run_cmd(r[0], 8'($urandom), len, wd, exp);
            step();
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_read_lat0();
        test_stall();
        test_reset_mid_write();
        test_back_to_back();
        repeat (3) @(negedge usb_clk);
        checks++;
        if (sb.size() != 0 || sb0.size() != 0) begin
            failures++;
            $display("FAIL rsp_missing: pending=%0d pending0=%0d, required 0 0", sb.size(), sb0.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
